// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end for a 5-stage RV32I pipeline. It owns the
// fetch PC, issues one word request per cycle to instruction memory (1-cycle
// read latency), and buffers returned {instr, pc} pairs in a small FIFO.
// Decode consumes the head entry one per cycle. A redirect from execute
// flushes the queue, drops any in-flight response and reloads the fetch PC.
//
// Parameters
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   imem_req/imem_addr    fetch request and address (current fetch PC)
//   imem_rdata            instruction word, valid 1 cycle after imem_req
//   redirect/redirect_pc  taken branch/jump and its target
//   stalld                decode cannot accept this cycle
//   validd/instrd/pcd/pcplus4d   head entry presented to decode
//   count                 entries currently held in the queue
//   misaligned            sticky misaligned-redirect flag
//
// Optional feature: define FETCH_MISALIGN_EN to flag redirects whose target
// has nonzero low bits; fetching then halts until reset. Without it the low
// two target bits are ignored and misaligned is always 0.
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       stalld,
    output logic                       validd,
    output logic [31:0]                instrd,
    output logic [31:0]                pcd,
    output logic [31:0]                pcplus4d,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       misaligned
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH+1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic          halt_fetch;
    logic [31:0]   redirect_target;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;

`ifdef FETCH_MISALIGN_EN
    logic misaligned_q, misaligned_d;

    assign redirect_target = redirect_pc;
    assign halt_fetch      = misaligned_q;

    always_comb begin
        misaligned_d = misaligned_q;
        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misaligned_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`else
    // Low target bits carry no meaning when misalignment is not tracked.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign halt_fetch          = 1'b0;
`endif

    // The in-flight word is counted as occupied so its response always has
    // a free slot; a pop in the same cycle is deliberately not credited.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue     = !reset && !redirect && !halt_fetch
                       && (occupancy < (CW+1)'(DEPTH));
    assign push      = inflight_q && !redirect && !reset;
    assign pop       = (count_q != '0) && !stalld && !redirect;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;

        if (redirect) begin
            pc_d       = redirect_target;
            inflight_d = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                pc_d          = pc_q + 32'd4;
                inflight_pc_d = pc_q;
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Entry storage needs no reset: validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= imem_rdata;
            pc_mem[tail_q]    <= inflight_pc_q;
        end
    end

    assign imem_req   = issue;
    assign imem_addr  = pc_q;
    assign validd     = (count_q != '0);
    assign instrd     = validd ? instr_mem[head_q] : NOP;
    assign pcd        = validd ? pc_mem[head_q] : 32'h0;
    assign pcplus4d   = pcd + 32'd4;
    assign count      = count_q;
    assign misaligned = halt_fetch;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed scenarios followed by a randomized phase. A queue-based reference
// model of the fetch front end predicts every output each cycle; outputs are
// sampled 1 ns after the falling edge, inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stalld;
    logic        validd;
    logic [31:0] instrd;
    logic [31:0] pcd;
    logic [31:0] pcplus4d;
    logic [2:0]  count;
    logic        misaligned;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stalld      (stalld),
        .validd      (validd),
        .instrd      (instrd),
        .pcd         (pcd),
        .pcplus4d    (pcplus4d),
        .count       (count),
        .misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] q_instr [$];
    logic [31:0] q_pc    [$];
    logic [31:0] m_pc     = 32'h0;
    logic        m_infl   = 1'b0;
    logic [31:0] m_infl_pc = 32'h0;
    logic        m_mis    = 1'b0;
    logic        m_known  = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
    endfunction

    function automatic logic exp_req(input logic r, input logic rd);
        return !r && !rd && !m_mis && ((q_pc.size() + int'(m_infl)) < int'(DEPTH));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input logic r, input logic rd);
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        e_instr = (q_pc.size() != 0) ? q_instr[0] : 32'h0000_0013;
        e_pc    = (q_pc.size() != 0) ? q_pc[0]    : 32'h0;
        chk("imem_req",   {31'h0, imem_req},   {31'h0, exp_req(r, rd)});
        chk("imem_addr",  imem_addr,           m_pc);
        chk("validd",     {31'h0, validd},     {31'h0, q_pc.size() != 0});
        chk("instrd",     instrd,              e_instr);
        chk("pcd",        pcd,                 e_pc);
        chk("pcplus4d",   pcplus4d,            e_pc + 32'd4);
        chk("count",      {29'h0, count},      32'(q_pc.size()));
        chk("misaligned", {31'h0, misaligned}, {31'h0, m_mis});
    endtask

    task automatic model_update(input logic r, input logic rd, input logic [31:0] rpc,
                                input logic st, input logic [31:0] rdata);
        logic req;
        if (r) begin
            q_instr.delete();
            q_pc.delete();
            m_pc    = RESET_PC;
            m_infl  = 1'b0;
            m_mis   = 1'b0;
            m_known = 1'b1;
        end else if (rd) begin
            q_instr.delete();
            q_pc.delete();
            m_infl = 1'b0;
`ifdef FETCH_MISALIGN_EN
            m_pc = rpc;
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
`else
            m_pc = rpc & ~32'h3;
`endif
        end else begin
            req = exp_req(1'b0, 1'b0);
            if (q_pc.size() != 0 && !st) begin
                $display("pop pc=%h instr=%h", q_pc[0], q_instr[0]);
                void'(q_pc.pop_front());
                void'(q_instr.pop_front());
            end
            if (m_infl) begin
                q_instr.push_back(rdata);
                q_pc.push_back(m_infl_pc);
            end
            if (req) begin
                m_infl_pc = m_pc;
                m_infl    = 1'b1;
                m_pc      = m_pc + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive inputs, check model against DUT, advance model.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic st);
        @(negedge clk);
        reset       = r;
        redirect    = rd;
        redirect_pc = rpc;
        stalld      = st;
        imem_rdata  = m_infl ? mem_word(m_infl_pc) : $urandom();
        #1;
        if (m_known) check_outputs(r, rd);
        @(posedge clk);
        model_update(r, rd, rpc, st, imem_rdata);
    endtask

    initial begin
        int guard;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stalld      = 1'b0;
        imem_rdata  = 32'h0;

        // Reset, then sequential fetch with free-flowing decode
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

        // Fill the queue under stall, then drain in order
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        #2;
        chk("full_count", {29'h0, count}, 32'd4);
        chk("full_addr",  imem_addr,      32'h10);
        chk("full_req",   {31'h0, imem_req}, 32'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

        // Redirect while count=3 and a request is in flight
        step(1, 0, 0, 0);
        guard = 0;
        while (!(q_pc.size() == 3 && m_infl) && guard < 10) begin
            step(0, 0, 0, 1);
            guard++;
        end
        chk("setup_reached", 32'(guard < 10), 32'd1);
        step(0, 1, 32'h100, 0);
        #2;
        chk("redir_count", {29'h0, count}, 32'd0);
        chk("redir_addr",  imem_addr,      32'h100);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        #2;
        chk("redir_validd", {31'h0, validd}, 32'd1);
        chk("redir_pcd",    pcd,             32'h100);

        // Redirect under stall still flushes
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        step(0, 1, 32'h200, 1);
        #2;
        chk("stall_redir_count", {29'h0, count}, 32'd0);
        step(0, 1, 32'h300, 0);
        step(0, 0, 0, 0);
        #2;
        chk("b2b_redir_addr", imem_addr, 32'h304);

        // PC wrap
        step(0, 1, 32'hFFFF_FFFC, 0);
        #2;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        #2;
        chk("wrap_addr1", imem_addr, 32'h0);
        step(0, 0, 0, 1);
        #2;
        chk("wrap_pcd",      pcd,      32'hFFFF_FFFC);
        chk("wrap_pcplus4d", pcplus4d, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // Randomized traffic (aligned redirect targets, occasional reset)
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 15) == 0,
                 {$urandom_range(0, 32'hFFFF), 16'h0} | (32'($urandom_range(0, 255)) << 2),
                 $urandom_range(0, 3) == 0);
        end

        // Misaligned redirect target
        step(0, 1, 32'h102, 0);
        #2;
`ifdef FETCH_MISALIGN_EN
        chk("mis_flag", {31'h0, misaligned}, 32'd1);
        chk("mis_addr", imem_addr, 32'h102);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        #2;
        chk("mis_req_held", {31'h0, imem_req}, 32'h0);
        step(1, 0, 0, 0);
        #2;
        chk("mis_cleared", {31'h0, misaligned}, 32'd0);
`else
        chk("mis_flag", {31'h0, misaligned}, 32'd0);
        chk("mis_addr", imem_addr, 32'h100);
`endif
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end of the 5-stage RV32I pipeline. It owns the fetch PC, issues word requests to the instruction memory, and buffers returned instructions in a small FIFO. It presents one instruction per cycle to the decode stage. Taken branches and jumps resolved in execute redirect the PC and flush all queued and in-flight instructions.

## Interface
- `DEPTH`, 4: queue entries (power of two, ≥2)
- `RESET_PC`, 32'h0000_0000: first fetch address after reset
- `clk` in 1: clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `imem_req` out 1: fetch request valid this cycle
- `imem_addr` out 32: fetch address (current fetch PC)
- `imem_rdata` in 32: instruction word, valid exactly 1 cycle after `imem_req`
- `redirect` in 1: taken branch/jump from execute
- `redirect_pc` in 32: redirect target
- `stalld` in 1: decode cannot accept this cycle
- `validd` out 1: `instrd`/`pcd`/`pcplus4d` hold a valid instruction
- `instrd` out 32: head instruction
- `pcd` out 32: PC of head instruction
- `pcplus4d` out 32: `pcd + 4`, mod 2^32
- `count` out $clog2(DEPTH+1): entries currently in queue
- `misaligned` out 1: sticky misaligned-redirect flag (see Configuration)

## Operation
- State: fetch PC, in-flight flag plus in-flight PC, FIFO of {instr, pc} with head/tail pointers and count, misaligned flag.
- Issue: `imem_req`=1 when not `reset`, not `redirect`, not `misaligned`, and `count + inflight < DEPTH`. A same-cycle pop is not credited. On issue, fetch PC <= PC + 4 (wraps 32'hFFFF_FFFC -> 0) and inflight <= 1 with the issued PC.
- Response: the cycle after an issue, {`imem_rdata`, in-flight PC} is pushed at tail unless killed.
- Pop: when `validd` && !`stalld`, head advances. Push and pop in the same cycle leave `count` unchanged.
- `validd` = (`count` != 0). `instrd`/`pcd` read combinationally from head. When empty, `instrd`=32'h0000_0013 (NOP) and `pcd`=0.
- Redirect (priority over push, pop, issue):
  - queue flushed (count <= 0, pointers reset)
  - in-flight response dropped
  - fetch PC <= `redirect_pc`
  - no request in the redirect cycle
- Redirect during `stalld` still flushes. Back-to-back redirects: the last one wins.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `validd`=0, `instrd`=32'h13, `pcd`=0, `pcplus4d`=4, `count`=0, `misaligned`=0. Any in-flight response is ignored.
- Reset asserted mid-operation takes effect at the next edge, identically to power-up reset.
- Latency:
  - request in cycle T -> data on `imem_rdata` in T+1 -> `validd` in T+2 (no bypass)
  - after redirect in cycle R -> request to `redirect_pc` in R+1 -> `validd` in R+3
- Throughput: 1 instruction/cycle sustained when `stalld`=0 and `DEPTH`≥4.
- Full: with `count + inflight = DEPTH`, `imem_req`=0 and the PC holds. The pending response always has a free slot.
- Empty with `stalld`=1: no state change on the decode side.

## Configuration
- `FETCH_MISALIGN_EN`:
  - Defined: a redirect with `redirect_pc[1:0] != 0` sets `misaligned` (sticky until reset). It flushes as a normal redirect, then fetching halts (`imem_req`=0). The fetch PC still loads `redirect_pc`.
  - Undefined: `misaligned` is tied to 0, and `redirect_pc[1:0]` is ignored (treated as 2'b00).

## Test plan
- Reset release at 15 ns with `RESET_PC`=0: `imem_addr` sequence 0,4,8,C…; `validd` rises 2 cycles after the first request. `pcd`/`pcplus4d` follow 0/4, 4/8, 8/C.
- Hold `stalld`=1 with `DEPTH`=4: `count` reaches 4, `imem_req` drops, and the PC holds at 0x10. On release, 0x0–0xC pop in order with no loss or duplication.
- `redirect`=1, `redirect_pc`=0x100 while `count`=3 and a request is in flight: next cycle `count`=0 and `imem_addr`=0x100. The old response is never seen, and `pcd`=0x100 two cycles later.
- `redirect` coincident with pop and with `stalld`=1: the queue flushes and the pop is discarded. `count`=0 next cycle.
- PC wrap: redirect to 0xFFFF_FFFC gives next `imem_addr`=0x0 and `pcplus4d`=0 for that entry.
- With `FETCH_MISALIGN_EN`, redirect to 0x102: `misaligned`=1 and `imem_req` stays 0 until `reset`. Without it, the next fetch is at 0x100 and `misaligned`=0.
